ether_frame_gen: RTL and testbench
==================================

ETHER_FRAME_GEN -- requirements
Module: ether_frame_gen

Interface
REQ-001 Parameter DATA_W, default 32, stream width in bits; legal values 32 and 64.
REQ-002 Parameter MIN_FRAME_BYTES, default 60, minimum frame length without FCS; shorter frames are zero-padded.
REQ-003 Parameter MAX_PAYLOAD, default 1480, largest payload byte count accepted.
REQ-004 Parameter IFG_CYCLES, default 12, idle cycles enforced after each frame.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 i_start  input  1  request one frame; sampled only in IDLE.
REQ-008 i_payload_len  input  11  payload bytes after the 34-byte header.
REQ-009 i_dst_mac / i_src_mac  input  48 each  MAC addresses.
REQ-010 i_ethertype  input  16  Ethernet type field.
REQ-011 i_ip_proto  input  8  IPv4 protocol field.
REQ-012 i_src_ip / i_dst_ip  input  32 each  IPv4 addresses.
REQ-013 i_pattern_seed  input  8  payload pattern seed.
REQ-014 o_rxd_tdata  output  DATA_W  stream data; byte 0 in bits [DATA_W-1:DATA_W-8].
REQ-015 o_rxd_tkeep  output  DATA_W/8  byte enables; MSB = byte 0.
REQ-016 o_rxd_tvalid / o_rxd_tlast  output  1 each  AXI-Stream valid, end of frame.
REQ-017 i_rxd_tready  input  1  downstream ready.
REQ-018 o_busy  output  1  high in SEND or GAP.
REQ-019 o_frame_cnt  output  16  completed frames, wraps 0xFFFF->0.

Function
REQ-020 The FSM SHALL have states IDLE, SEND, GAP: IDLE->SEND on i_start; SEND->GAP on the handshake of the tlast beat; GAP->IDLE after IFG_CYCLES cycles (IFG_CYCLES=0: SEND->IDLE directly).
REQ-021 On IDLE&&i_start all i_* config inputs SHALL be latched; later input changes SHALL not affect the frame in flight.
REQ-022 The payload length SHALL be clamped to MAX_PAYLOAD when latched.
REQ-023 o_rxd_tvalid SHALL assert the cycle after i_start is sampled, and SHALL stay high until the tlast handshake.
REQ-024 While tvalid&&!tready, tdata, tkeep and tlast SHALL hold stable; the byte offset SHALL advance only on tvalid&&tready.
REQ-025 Frame length L SHALL be max(34+payload_len, MIN_FRAME_BYTES); beats = ceil(L/(DATA_W/8)).
REQ-026 Header bytes, big-endian: 0-5 dst MAC; 6-11 src MAC; 12-13 ethertype; 14=0x45; 15=0x00; 16-17=20+payload_len; 18-19=o_frame_cnt; 20-21=0x4000; 22=0x40; 23=ip_proto; 24-25=0x0000; 26-29 src IP; 30-33 dst IP.
REQ-027 Payload byte k (k=0..payload_len-1) SHALL equal k[7:0] XOR i_pattern_seed; pad bytes SHALL be 0x00.
REQ-028 tkeep SHALL be all-ones except on the last beat, where it SHALL mark exactly the remaining (L mod DATA_W/8, or full) bytes MSB-first; unused bytes SHALL drive 0x00.
REQ-029 tlast SHALL be high only on the final beat.
REQ-030 o_frame_cnt SHALL increment on the tlast handshake.
REQ-031 i_start in SEND or GAP SHALL be ignored and not queued.
REQ-032 i_start in IDLE on the cycle after GAP ends SHALL be accepted.

Reset
REQ-033 With rst low: state IDLE; o_rxd_tvalid=0, o_rxd_tlast=0, o_rxd_tdata=0, o_rxd_tkeep=0, o_busy=0, o_frame_cnt=0; GAP counter and byte offset cleared.
REQ-034 Reset asserted mid-frame SHALL drop tvalid immediately (asynchronously) with no tlast emitted; the partial frame SHALL not be counted.

Verification
REQ-035 DATA_W=32, dst=0x8000207A3F3E, payload_len=10, tready=1 -> 15 beats, beat0 tdata=0x8000207A, tlast on beat 15, tkeep=0xF on all beats, bytes 44-59=0x00.
REQ-036 DATA_W=32, payload_len=27, seed=0xA5 -> L=61, 16 beats, last tkeep=0x8, byte 34=0xA5, byte 35=0xA4, bytes 16-17=0x002F.
REQ-037 DATA_W=64, payload_len=100 -> L=134, 17 beats, last tkeep=0xFC.
REQ-038 tready toggled 1/0 randomly during REQ-035 -> identical byte sequence, stable outputs during each stall, o_frame_cnt=1.
REQ-039 i_start pulsed during SEND and during GAP -> ignored; the next frame starts only after IFG_CYCLES=12 idle cycles; o_frame_cnt=1.
REQ-040 rst low at beat 5 -> tvalid=0 and o_frame_cnt=0 at once; the next i_start yields a complete frame with ID field bytes 18-19=0x0000.

Source files
------------

// File: rtl/ether_frame_gen.sv
// ether_frame_gen: AXI-Stream generator of Ethernet/IPv4 test frames with a
// pattern payload, zero padding to a minimum length and an enforced inter-frame gap.
module ether_frame_gen #(
    parameter int DATA_W          = 32,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int MAX_PAYLOAD     = 1480,
    parameter int IFG_CYCLES      = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [10:0]         i_payload_len,
    input  logic [47:0]         i_dst_mac,
    input  logic [47:0]         i_src_mac,
    input  logic [15:0]         i_ethertype,
    input  logic [7:0]          i_ip_proto,
    input  logic [31:0]         i_src_ip,
    input  logic [31:0]         i_dst_ip,
    input  logic [7:0]          i_pattern_seed,
    output logic [DATA_W-1:0]   o_rxd_tdata,
    output logic [DATA_W/8-1:0] o_rxd_tkeep,
    output logic                o_rxd_tvalid,
    output logic                o_rxd_tlast,
    input  logic                i_rxd_tready,
    output logic                o_busy,
    output logic [15:0]         o_frame_cnt
);
    localparam int          NB       = DATA_W / 8;
    localparam logic [11:0] MIN_L    = 12'(MIN_FRAME_BYTES);
    localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
    localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    typedef struct packed {
        logic [10:0] len;
        logic [47:0] dst, src;
        logic [15:0] etype;
        logic [7:0]  proto;
        logic [31:0] sip, dip;
        logic [7:0]  seed;
        logic [15:0] id;
    } cfg_t;

    state_t            state_q;
    cfg_t              cfg_q, cfg_d, gen_cfg;
    logic [11:0]       off_q, gen_off;
    logic [15:0]       gap_q, cnt_q;
    logic [DATA_W-1:0] data_q, gen_data;
    logic [NB-1:0]     keep_q, gen_keep;
    logic              valid_q, last_q, gen_last;

    function automatic logic [11:0] frame_len(cfg_t c);
        logic [11:0] l;
        l = 12'd34 + {1'b0, c.len};
        return l < MIN_L ? MIN_L : l;
    endfunction

    // Bytes past the payload (padding and unused lanes) fall out as zero.
    function automatic logic [7:0] frame_byte(cfg_t c, logic [11:0] idx);
        logic [271:0] hdr;
        logic [11:0]  p;
        hdr = {c.dst, c.src, c.etype, 16'h4500, 16'd20 + {5'b0, c.len}, c.id,
               16'h4000, 8'h40, c.proto, 16'h0000, c.sip, c.dip};
        hdr = hdr << {idx, 3'b000};
        p = idx - 12'd34;
        return idx < 12'd34 ? hdr[271:264] : p < {1'b0, c.len} ? p[7:0] ^ c.seed : 8'h00;
    endfunction

    always_comb begin
        cfg_d.len   = i_payload_len > MAX_LEN ? MAX_LEN : i_payload_len;
        cfg_d.dst   = i_dst_mac;
        cfg_d.src   = i_src_mac;
        cfg_d.etype = i_ethertype;
        cfg_d.proto = i_ip_proto;
        cfg_d.sip   = i_src_ip;
        cfg_d.dip   = i_dst_ip;
        cfg_d.seed  = i_pattern_seed;
        cfg_d.id    = cnt_q;
    end

    // In IDLE the first beat is built straight from the inputs being latched.
    assign gen_cfg = state_q == IDLE ? cfg_d : cfg_q;
    assign gen_off = state_q == IDLE ? 12'd0 : off_q + 12'(NB);

    always_comb begin
        gen_data = '0;
        gen_keep = '0;
        for (int j = 0; j < NB; j++) begin
            gen_data[DATA_W-1-8*j -: 8] = frame_byte(gen_cfg, gen_off + 12'(j));
            gen_keep[NB-1-j]            = gen_off + 12'(j) < frame_len(gen_cfg);
        end
        gen_last = gen_off + 12'(NB) >= frame_len(gen_cfg);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            off_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    state_q <= SEND;
                    cfg_q   <= cfg_d;
                    off_q   <= '0;
                    data_q  <= gen_data;
                    keep_q  <= gen_keep;
                    last_q  <= gen_last;
                    valid_q <= 1'b1;
                end
                SEND: if (i_rxd_tready) begin
                    if (last_q) begin
                        state_q <= IFG_CYCLES == 0 ? IDLE : GAP;
                        gap_q   <= '0;
                        cnt_q   <= cnt_q + 16'd1;
                        data_q  <= '0;
                        keep_q  <= '0;
                        last_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end else begin
                        off_q  <= gen_off;
                        data_q <= gen_data;
                        keep_q <= gen_keep;
                        last_q <= gen_last;
                    end
                end
                GAP: begin
                    gap_q <= gap_q + 16'd1;
                    if (gap_q == GAP_LAST) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_rxd_tdata  = data_q;
    assign o_rxd_tkeep  = keep_q;
    assign o_rxd_tvalid = valid_q;
    assign o_rxd_tlast  = last_q;
    assign o_busy       = state_q != IDLE;
    assign o_frame_cnt  = cnt_q;
endmodule

// File: tb/tb_ether_frame_gen.sv
// tb_ether_frame_gen: drives a 32-bit and a 64-bit generator and checks every
// cycle against a byte-queue frame model, plus hand-computed frame literals.
module tb_ether_frame_gen;
    localparam int IFG  = 12;
    localparam int MINF = 60;
    localparam int MAXP = 1480;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  start  = 2'b00;
    logic [1:0]  tready = 2'b00;
    logic [10:0] plen   = '0;
    logic [47:0] dst = '0, src = '0;
    logic [15:0] etype = '0;
    logic [7:0]  proto = '0, seed = '0;
    logic [31:0] sip = '0, dip = '0;

    logic [31:0] td32;
    logic [3:0]  tk32;
    logic [63:0] td64;
    logic [7:0]  tk64;
    logic        tv32, tl32, bz32, tv64, tl64, bz64;
    logic [15:0] cnt32, cnt64;

    ether_frame_gen #(.DATA_W(32)) u32 (
        .clk(clk), .rst(rst), .i_start(start[0]), .i_payload_len(plen),
        .i_dst_mac(dst), .i_src_mac(src), .i_ethertype(etype), .i_ip_proto(proto),
        .i_src_ip(sip), .i_dst_ip(dip), .i_pattern_seed(seed),
        .o_rxd_tdata(td32), .o_rxd_tkeep(tk32), .o_rxd_tvalid(tv32), .o_rxd_tlast(tl32),
        .i_rxd_tready(tready[0]), .o_busy(bz32), .o_frame_cnt(cnt32));

    ether_frame_gen #(.DATA_W(64)) u64 (
        .clk(clk), .rst(rst), .i_start(start[1]), .i_payload_len(plen),
        .i_dst_mac(dst), .i_src_mac(src), .i_ethertype(etype), .i_ip_proto(proto),
        .i_src_ip(sip), .i_dst_ip(dip), .i_pattern_seed(seed),
        .o_rxd_tdata(td64), .o_rxd_tkeep(tk64), .o_rxd_tvalid(tv64), .o_rxd_tlast(tl64),
        .i_rxd_tready(tready[1]), .o_busy(bz64), .o_frame_cnt(cnt64));

    byte unsigned q[2][$];
    byte unsigned rx[2][$];
    byte unsigned ref_rx[$];
    int          gap_left[2], nbeats[2], beats_done[2], idle_run[2], idle_seen[2];
    logic [15:0] mcnt[2];
    logic [63:0] first_d[2], pd[2];
    logic [7:0]  last_k[2], pk[2];
    logic        stall[2], pl[2];
    int          ready_pct = 100;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void put(int w, logic [63:0] v, int n);
        for (int i = n - 1; i >= 0; i--) q[w].push_back(v[8*i +: 8]);
    endfunction

    // Whole expected frame as a byte list, straight from the field layout.
    function automatic void build(int w);
        int len, fl;
        len = int'(plen) > MAXP ? MAXP : int'(plen);
        fl  = 34 + len < MINF ? MINF : 34 + len;
        q[w].delete();
        put(w, 64'(dst), 6); put(w, 64'(src), 6); put(w, 64'(etype), 2);
        put(w, 64'h4500, 2); put(w, 64'(20 + len), 2); put(w, 64'(mcnt[w]), 2);
        put(w, 64'h4000, 2); put(w, 64'h40, 1); put(w, 64'(proto), 1); put(w, 64'h0, 2);
        put(w, 64'(sip), 4); put(w, 64'(dip), 4);
        for (int i = 0; i < len; i++) q[w].push_back(8'(i) ^ seed);
        while (q[w].size() < fl) q[w].push_back(8'h00);
    endfunction

    task automatic mon();
        logic [63:0] d, ed;
        logic [7:0]  k, ek;
        logic [15:0] c;
        logic        v, l, b, idle, el;
        int          nb;
        string       pre;
        for (int w = 0; w < 2; w++) begin
            nb  = w == 1 ? 8 : 4;
            pre = w == 1 ? "w64" : "w32";
            d   = w == 1 ? td64 : {32'b0, td32};
            k   = w == 1 ? tk64 : {4'b0, tk32};
            v   = w == 1 ? tv64 : tv32;
            l   = w == 1 ? tl64 : tl32;
            b   = w == 1 ? bz64 : bz32;
            c   = w == 1 ? cnt64 : cnt32;
            if (!rst) begin
                chk({pre, "_reset_ctrl"}, 64'({v, l, b, c}), 64'h0);
                chk({pre, "_reset_data"}, d, 64'h0);
                chk({pre, "_reset_keep"}, 64'(k), 64'h0);
                q[w].delete();
                gap_left[w] = 0;
                mcnt[w]     = '0;
                stall[w]    = 1'b0;
                idle_run[w] = 0;
            end else begin
                idle = q[w].size() == 0 && gap_left[w] == 0;
                if (gap_left[w] > 0) gap_left[w]--;
                chk({pre, "_busy"}, 64'(b), 64'(!idle));
                chk({pre, "_frame_cnt"}, 64'(c), 64'(mcnt[w]));
                chk({pre, "_tvalid"}, 64'(v), 64'(q[w].size() != 0));
                if (stall[w]) begin
                    chk({pre, "_stall_data"}, d, pd[w]);
                    chk({pre, "_stall_keep_last"}, 64'({k, l}), 64'({pk[w], pl[w]}));
                end
                if (!v) idle_run[w]++;
                else if (idle_run[w] != 0) begin
                    idle_seen[w] = idle_run[w];
                    idle_run[w]  = 0;
                end
                tready[w] = $urandom_range(99) < ready_pct;
                stall[w]  = v && !tready[w];
                pd[w] = d;
                pk[w] = k;
                pl[w] = l;
                if (v && tready[w] && q[w].size() != 0) begin
                    ed = '0;
                    ek = '0;
                    for (int j = 0; j < nb; j++)
                        if (q[w].size() != 0) begin
                            ed[8*(nb-1-j) +: 8] = q[w].pop_front();
                            ek[nb-1-j] = 1'b1;
                        end
                    el = q[w].size() == 0;
                    chk({pre, "_beat_data"}, d, ed);
                    chk({pre, "_beat_keep_last"}, 64'({k, l}), 64'({ek, el}));
                    for (int j = 0; j < nb; j++)
                        if (k[nb-1-j]) rx[w].push_back(d[8*(nb-1-j) +: 8]);
                    if (nbeats[w] == 0) first_d[w] = d;
                    nbeats[w]++;
                    if (el) begin
                        beats_done[w] = nbeats[w];
                        last_k[w]     = k;
                        mcnt[w]       = mcnt[w] + 16'd1;
                        gap_left[w]   = IFG;
                        idle_run[w]   = 0;
                    end
                end
                if (idle && start[w]) begin
                    build(w);
                    rx[w].delete();
                    nbeats[w] = 0;
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #2;
    endtask

    task automatic go(input logic [1:0] m);
        start = m;
        cyc();
        start = 2'b00;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(q[0].size() == 0 && q[1].size() == 0 && gap_left[0] == 0 && gap_left[1] == 0)
               && t < 20000) begin
            cyc();
            t++;
        end
        if (t >= 20000) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic rnd_cfg();
        plen  = $urandom_range(7) == 0 ? 11'($urandom) : 11'($urandom_range(120));
        dst   = 48'({$urandom, $urandom});
        src   = 48'({$urandom, $urandom});
        etype = 16'($urandom);
        proto = 8'($urandom);
        sip   = $urandom;
        dip   = $urandom;
        seed  = 8'($urandom);
    endtask

    initial begin
        int          t, mism;
        logic [7:0]  acc;
        rnd_cfg();
        #1 rst = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();

        ready_pct = 100;
        dst  = 48'h8000207A3F3E;
        plen = 11'd10;
        go(2'b11);
        wait_idle();
        chk("A_beats32", 64'(beats_done[0]), 64'd15);
        chk("A_first32", first_d[0], 64'h8000207A);
        chk("A_lastkeep32", 64'(last_k[0]), 64'hF);
        chk("A_len32", 64'(rx[0].size()), 64'd60);
        acc = '0;
        for (int i = 44; i < 60 && i < rx[0].size(); i++) acc |= rx[0][i];
        chk("A_pad32", 64'(acc), 64'h0);
        chk("A_beats64", 64'(beats_done[1]), 64'd8);
        chk("A_lastkeep64", 64'(last_k[1]), 64'hF0);
        ref_rx = rx[0];

        ready_pct = 50;
        go(2'b01);
        t = 0;
        while (nbeats[0] < 5 && t < 200) begin
            cyc();
            t++;
        end
        if (t >= 200) chk("C_beat_timeout", 64'd1, 64'd0);
        rst = 1'b0;
        #1;
        chk("C_rst_tvalid", 64'(tv32), 64'd0);
        chk("C_rst_cnt", 64'(cnt32), 64'd0);
        cyc();
        rst = 1'b1;
        cyc();

        go(2'b11);
        wait_idle();
        mism = rx[0].size() != ref_rx.size() ? 1 : 0;
        for (int i = 0; i < rx[0].size() && i < ref_rx.size(); i++)
            if (rx[0][i] != ref_rx[i]) mism++;
        chk("B_same_bytes", 64'(mism), 64'd0);
        chk("B_cnt", 64'(cnt32), 64'd1);
        if (rx[0].size() > 19) chk("B_id", 64'({rx[0][18], rx[0][19]}), 64'h0);
        else chk("B_short", 64'(rx[0].size()), 64'd60);

        ready_pct = 100;
        plen = 11'd27;
        seed = 8'hA5;
        go(2'b11);
        wait_idle();
        chk("D_beats32", 64'(beats_done[0]), 64'd16);
        chk("D_lastkeep32", 64'(last_k[0]), 64'h8);
        chk("D_beats64", 64'(beats_done[1]), 64'd8);
        chk("D_lastkeep64", 64'(last_k[1]), 64'hF8);
        if (rx[0].size() == 61) begin
            chk("D_byte34", 64'(rx[0][34]), 64'hA5);
            chk("D_byte35", 64'(rx[0][35]), 64'hA4);
            chk("D_iplen", 64'({rx[0][16], rx[0][17]}), 64'h002F);
        end else chk("D_len32", 64'(rx[0].size()), 64'd61);

        plen = 11'd100;
        go(2'b11);
        wait_idle();
        chk("E_beats64", 64'(beats_done[1]), 64'd17);
        chk("E_lastkeep64", 64'(last_k[1]), 64'hFC);
        chk("E_beats32", 64'(beats_done[0]), 64'd34);
        chk("E_lastkeep32", 64'(last_k[0]), 64'hC);

        plen = 11'd20;
        go(2'b01);
        start = 2'b01;
        repeat (3) cyc();
        start = 2'b00;
        t = 0;
        while (q[0].size() != 0 && t < 500) begin
            cyc();
            t++;
        end
        start = 2'b01;
        while (q[0].size() == 0 && t < 600) begin
            cyc();
            t++;
        end
        start = 2'b00;
        if (t >= 500) chk("F_timeout", 64'd1, 64'd0);
        wait_idle();
        chk("F_idle_gap", 64'(idle_seen[0]), 64'(IFG + 1));

        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(19) == 0) rnd_cfg();
            start = $urandom_range(7) == 0 ? 2'($urandom) : 2'b00;
            if ($urandom_range(199) == 0) ready_pct = $urandom_range(100, 20);
            cyc();
        end
        start = 2'b00;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
